// File: rtl/sts_fault_reporter.sv
// sts_fault_reporter
//   Turns rising edges on NUM_SRC synchronized status vectors into reports on a
//   valid/ready stream. Each source keeps a pending mask (bits that have risen
//   but are not yet reported) and a sticky mask (bits that have risen since the
//   last clear). A round-robin arbiter grants one pending source at a time, so
//   simultaneous faults are all delivered and none can starve the others.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active high
//   enable        0 masks new-event detection (pending reports still drain)
//   clear         one-cycle pulse clearing sticky and pending state
//   sts_in        status, source s at bits [s*WIDTH +: WIDTH]
//   report_data   {source index, channel mask}
//   report_valid  report available
//   report_ready  consumer accepts report
//   pending       per source: some bit has risen and is not yet reported
//   sticky        bits that have risen since the last clear
//   report_count  accepted reports, saturating at 16'hFFFF
module sts_fault_reporter #(
  parameter int NUM_SRC = 12,
  parameter int WIDTH   = 8,
  parameter int CODE_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NUM_SRC*WIDTH-1:0]  sts_in,
  output logic [CODE_W+WIDTH-1:0]   report_data,
  output logic                      report_valid,
  input  logic                      report_ready,
  output logic [NUM_SRC-1:0]        pending,
  output logic [NUM_SRC*WIDTH-1:0]  sticky,
  output logic [15:0]               report_count
);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t                     state_reg;
  logic [NUM_SRC*WIDTH-1:0]   prev_reg;
  logic [NUM_SRC*WIDTH-1:0]   pend_mask_reg;
  logic [NUM_SRC*WIDTH-1:0]   sticky_reg;
  logic [CODE_W-1:0]          rr_ptr_reg;

  logic [NUM_SRC*WIDTH-1:0]   rise;
  logic [NUM_SRC*WIDTH-1:0]   capture;
  logic                       grant_found;
  logic [CODE_W-1:0]          grant_idx;
  logic [WIDTH-1:0]           grant_mask;
  logic                       take;

  // Edge detect against last cycle's sample; prev_reg tracks sts_in even while
  // disabled, so levels already high at enable time are not reported.
  assign rise = sts_in & ~prev_reg & {(NUM_SRC*WIDTH){enable}};

  // The FSM takes a mask only from IDLE when something is pending.
  assign take = (state_reg == IDLE) && grant_found;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign pending[gi] = |pend_mask_reg[gi*WIDTH +: WIDTH];
      // Only the granted source's slice is removed from its pending mask.
      assign capture[gi*WIDTH +: WIDTH] =
        (take && (grant_idx == CODE_W'(gi))) ? pend_mask_reg[gi*WIDTH +: WIDTH]
                                             : '0;
    end
  endgenerate

  // Round-robin search: first pending source after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CODE_W'(idx);
      end
    end
  end

  assign grant_mask = pend_mask_reg[grant_idx*WIDTH +: WIDTH];

  // Event bookkeeping. A rise in the same cycle as clear or capture survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg      <= '0;
      pend_mask_reg <= '0;
      sticky_reg    <= '0;
    end else begin
      prev_reg      <= sts_in;
      pend_mask_reg <= clear ? rise : ((pend_mask_reg & ~capture) | rise);
      sticky_reg    <= clear ? rise : (sticky_reg | rise);
    end
  end

  assign sticky = sticky_reg;

  // Report FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= CODE_W'(NUM_SRC - 1);
      report_data  <= '0;
      report_valid <= 1'b0;
      report_count <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            report_data  <= {grant_idx, grant_mask};
            report_valid <= 1'b1;
            rr_ptr_reg   <= grant_idx;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (report_valid && report_ready) begin
            report_valid <= 1'b0;
            if (report_count != 16'hFFFF) report_count <= report_count + 16'd1;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sts_fault_reporter.sv
// Directed bench for sts_fault_reporter. Inputs are driven and outputs sampled
// on the falling clock edge; every comparison goes through check_val.
module tb_sts_fault_reporter;

  localparam int NUM_SRC = 12;
  localparam int WIDTH   = 8;
  localparam int CODE_W  = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enable;
  logic                      clear;
  logic [NUM_SRC*WIDTH-1:0]  sts_in;
  logic [CODE_W+WIDTH-1:0]   report_data;
  logic                      report_valid;
  logic                      report_ready;
  logic [NUM_SRC-1:0]        pending;
  logic [NUM_SRC*WIDTH-1:0]  sticky;
  logic [15:0]               report_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  sts_fault_reporter #(.NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear        (clear),
    .sts_in       (sts_in),
    .report_data  (report_data),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .pending      (pending),
    .sticky       (sticky),
    .report_count (report_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_src(input int s, input logic [7:0] v);
    sts_in[s*WIDTH +: WIDTH] = v;
  endtask

  // Bounded wait for report_valid; an expired bound counts as a failure.
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !report_valid; i++) tick();
    check_val({tag, "_valid"}, 96'(report_valid), 96'd1);
  endtask

  // Wait for a report, check its content, accept it and check the count.
  task automatic get_report(input string tag, input logic [11:0] exp);
    wait_valid(tag);
    check_val({tag, "_data"}, 96'(report_data), 96'(exp));
    $display("report src=%0d mask=%02h", report_data[11:8], report_data[7:0]);
    report_ready = 1'b1;
    tick();
    exp_count++;
    check_val({tag, "_done"}, 96'(report_valid), 96'd0);
    check_val({tag, "_count"}, 96'(report_count), 96'(exp_count));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; report_ready = 1'b0; sts_in = '0;
    tick();
    check_val("rst_valid", 96'(report_valid), 96'd0);
    check_val("rst_data", 96'(report_data), 96'd0);
    check_val("rst_pending", 96'(pending), 96'd0);
    check_val("rst_sticky", sticky, 96'd0);
    check_val("rst_count", 96'(report_count), 96'd0);
    rst = 1'b0;
    enable = 1'b1; report_ready = 1'b1;
    tick();

    // Single event with latency check.
    set_src(3, 8'h05);
    tick();
    check_val("t1_lat0_valid", 96'(report_valid), 96'd0);
    check_val("t1_pending", 96'(pending), 96'h008);
    tick();
    check_val("t1_lat1_valid", 96'(report_valid), 96'd1);
    get_report("t1", 12'h305);
    check_val("t1_sticky", 96'(sticky[31:24]), 96'h05);
    check_val("t1_pend_after", 96'(pending), 96'd0);
    set_src(3, 8'h00);
    tick();

    // Simultaneous sources, round-robin from a fresh reset.
    do_reset();
    check_val("t2_count0", 96'(report_count), 96'd0);
    set_src(0, 8'h01); set_src(5, 8'h80); set_src(11, 8'h10);
    get_report("t2a", 12'h001);
    get_report("t2b", 12'h580);
    get_report("t2c", 12'hB10);
    set_src(0, 8'h00); set_src(5, 8'h00);
    tick();
    set_src(0, 8'h01); set_src(5, 8'h80);
    get_report("t2d", 12'h001);
    get_report("t2e", 12'h580);

    // Backpressure and merge behind an in-flight report.
    report_ready = 1'b0;
    set_src(2, 8'h01);
    wait_valid("t3w");
    set_src(2, 8'h03);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t3_hold_data", 96'(report_data), 96'h201);
      check_val("t3_hold_valid", 96'(report_valid), 96'd1);
    end
    check_val("t3_pend2", 96'(pending[2]), 96'd1);
    get_report("t3a", 12'h201);
    get_report("t3b", 12'h202);
    check_val("t3_pend2_after", 96'(pending[2]), 96'd0);

    // Enable masking.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("t4_clr_sticky", sticky, 96'd0);
    enable = 1'b0;
    set_src(1, 8'hFF);
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_val("t4_no_valid", 96'(report_valid), 96'd0);
    check_val("t4_no_pend", 96'(pending), 96'd0);
    check_val("t4_sticky", sticky, 96'd0);
    set_src(1, 8'hFE);
    tick();
    set_src(1, 8'hFF);
    get_report("t4", 12'h101);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t4_once", 96'(report_valid), 96'd0);
    end

    // Clear versus rise in the same cycle.
    set_src(4, 8'h0F);
    get_report("t5a", 12'h40F);
    check_val("t5_sticky_pre", 96'(sticky[39:32]), 96'h0F);
    set_src(4, 8'h8F);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("t5_sticky", sticky, 96'h80 << 32);
    check_val("t5_pend4", 96'(pending[4]), 96'd1);
    get_report("t5b", 12'h480);

    // Clear during SEND keeps the in-flight report.
    report_ready = 1'b0;
    set_src(6, 8'h04);
    wait_valid("t5w");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("t5_clr_valid", 96'(report_valid), 96'd1);
    check_val("t5_clr_sticky", 96'(sticky[55:48]), 96'd0);
    get_report("t5c", 12'h604);

    // Asynchronous reset while a report is in flight.
    report_ready = 1'b0;
    set_src(7, 8'h01);
    wait_valid("t6w");
    #2 rst = 1'b1;
    #1;
    check_val("t6_valid", 96'(report_valid), 96'd0);
    check_val("t6_data", 96'(report_data), 96'd0);
    check_val("t6_count", 96'(report_count), 96'd0);
    check_val("t6_pending", 96'(pending), 96'd0);
    check_val("t6_sticky", sticky, 96'd0);
    sts_in = '0;
    tick();
    rst = 1'b0;
    exp_count = 0;
    set_src(0, 8'h02); set_src(7, 8'h01);
    get_report("t6a", 12'h002);
    get_report("t6b", 12'h701);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
